crc_mem_scrub_ctrl: RTL and testbench

Access controller for the CRC-protected 32-bit MEM1 port of `dut`. It arbitrates a host request port against a background scrubber that periodically reads every address. It writes corrected data back when the memory reports a correctable error, and keeps saturating error counters with a sticky interrupt. It sits between the test/host logic and the `mem1_*` pins of `dut`.

---
 rtl/crc_mem_scrub_ctrl_pkg.sv | 27 ++
 rtl/crc_mem_scrub_ctrl_if.sv | 53 +++++
 rtl/crc_mem_scrub_ctrl_err_sat_cnt.sv | 36 +++
 rtl/crc_mem_scrub_ctrl.sv | 167 ++++++++++++++++
 tb/tb_crc_mem_scrub_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/crc_mem_scrub_ctrl_pkg.sv
//==============================================================================
// Module : crc_scrub_pkg
// Brief  : Shared types and default constants for the MEM1 scrub controller.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package crc_scrub_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SCRUB_RD  = 2'd1,
      SCRUB_CHK = 2'd2,
      SCRUB_WB  = 2'd3
   } scrub_state_t;

   typedef enum logic {
      OWN_HOST  = 1'b0,
      OWN_SCRUB = 1'b1
   } owner_t;

   localparam int c_DEF_SCRUB_INTERVAL = 64;
   localparam int c_DEF_STARVE_LIMIT   = 16;

endpackage

`default_nettype wire

// File: rtl/crc_mem_scrub_ctrl_if.sv
//==============================================================================
// Module : crc_mem_scrub_ctrl_if
// Brief  : Host, memory and status signals of the MEM1 scrub controller.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface crc_mem_scrub_ctrl_if #(
   parameter int AW    = 8,
   parameter int DW    = 32,
   parameter int CNT_W = 8
);
   logic             host_req;
   logic             host_wr;
   logic [AW-1:0]    host_addr;
   logic [DW-1:0]    host_wdata;
   logic             host_gnt;
   logic             host_rvalid;
   logic [DW-1:0]    host_rdata;
   logic             host_rerr;
   logic             mem_wr;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [DW-1:0]    mem_rdata;
   logic             mem_err_detected;
   logic             mem_err_corrected;
   logic             scrub_en;
   logic             cnt_clr;
   logic [CNT_W-1:0] corr_cnt;
   logic [CNT_W-1:0] uncorr_cnt;
   logic             err_irq;
   logic             scrub_pass_done;

   modport master (
      output host_req, host_wr, host_addr, host_wdata,
      output mem_rdata, mem_err_detected, mem_err_corrected,
      output scrub_en, cnt_clr,
      input  host_gnt, host_rvalid, host_rdata, host_rerr,
      input  mem_wr, mem_addr, mem_wdata,
      input  corr_cnt, uncorr_cnt, err_irq, scrub_pass_done
   );

   modport slave (
      input  host_req, host_wr, host_addr, host_wdata,
      input  mem_rdata, mem_err_detected, mem_err_corrected,
      input  scrub_en, cnt_clr,
      output host_gnt, host_rvalid, host_rdata, host_rerr,
      output mem_wr, mem_addr, mem_wdata,
      output corr_cnt, uncorr_cnt, err_irq, scrub_pass_done
   );
endinterface

`default_nettype wire

// File: rtl/crc_mem_scrub_ctrl_err_sat_cnt.sv
//==============================================================================
// Module : err_sat_cnt
// Brief  : Saturating event counter; a clear in the same cycle as an event
//          leaves a count of one.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module err_sat_cnt #(
   parameter int W = 8
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         i_inc,
   input  wire logic         i_clr,
   output logic      [W-1:0] o_cnt
);
   localparam logic [W-1:0] c_MAX = '1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= W'(i_inc);
      end else if (i_inc && (r_cnt != c_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/crc_mem_scrub_ctrl.sv
//==============================================================================
// Module : crc_mem_scrub_ctrl
// Brief  : Arbitrates host accesses against a background scrubber on MEM1,
//          writes back corrected data and tracks ECC error statistics.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module crc_mem_scrub_ctrl
   import crc_scrub_pkg::*;
#(
   parameter int AW             = 8,
   parameter int DW             = 32,
   parameter int SCRUB_INTERVAL = c_DEF_SCRUB_INTERVAL,
   parameter int STARVE_LIMIT   = c_DEF_STARVE_LIMIT,
   parameter int CNT_W          = 8
) (
   input wire logic          clk,
   input wire logic          rst_n,
   crc_mem_scrub_ctrl_if.slave io_bus
);
   localparam int c_IW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
   localparam int c_SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_IW-1:0] c_IVL_LAST   = c_IW'(SCRUB_INTERVAL - 1);
   localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(STARVE_LIMIT);
   localparam logic [AW-1:0]   c_PTR_LAST   = '1;

   scrub_state_t    r_state;
   logic [c_IW-1:0] r_ivl;
   logic [c_SW-1:0] r_starve;
   logic [AW-1:0]   r_scrub_ptr;
   logic [AW-1:0]   r_mem_addr;
   logic [DW-1:0]   r_mem_wdata;
   logic            r_mem_wr;
   logic            r_rd1;
   logic            r_rd2;
   owner_t          r_own1;
   owner_t          r_own2;
   logic            r_pass_done;
   logic            r_irq;

   logic w_idle, w_expired, w_blocked, w_force, w_gnt, w_issue;
   logic w_host_resp, w_corr, w_uncorr, w_chk_wb, w_ptr_adv;

   assign w_idle      = (r_state == IDLE);
   assign w_expired   = (r_ivl == c_IVL_LAST);
   assign w_blocked   = w_idle & io_bus.scrub_en & w_expired;
   assign w_force     = w_blocked & (r_starve == c_STARVE_MAX);
   assign w_gnt       = rst_n & io_bus.host_req & w_idle & ~w_force;
   assign w_issue     = w_blocked & (~io_bus.host_req | w_force);
   assign w_host_resp = r_rd2 & (r_own2 == OWN_HOST);
   assign w_corr      = r_rd2 & io_bus.mem_err_detected & io_bus.mem_err_corrected;
   assign w_uncorr    = r_rd2 & io_bus.mem_err_detected & ~io_bus.mem_err_corrected;
   assign w_chk_wb    = (r_state == SCRUB_CHK) & io_bus.mem_err_detected
                        & io_bus.mem_err_corrected;
   assign w_ptr_adv   = ((r_state == SCRUB_CHK) & ~w_chk_wb) | (r_state == SCRUB_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_ivl       <= '0;
         r_starve    <= '0;
         r_scrub_ptr <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_wr    <= 1'b0;
         r_rd1       <= 1'b0;
         r_rd2       <= 1'b0;
         r_own1      <= OWN_HOST;
         r_own2      <= OWN_HOST;
         r_pass_done <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_mem_wr    <= 1'b0;
         r_rd1       <= 1'b0;
         r_own1      <= OWN_HOST;
         r_rd2       <= r_rd1;
         r_own2      <= r_own1;
         r_pass_done <= 1'b0;

         if (!io_bus.scrub_en || w_issue) begin
            r_ivl <= '0;
         end else if (w_idle && !w_expired) begin
            r_ivl <= r_ivl + 1'b1;
         end

         if (!io_bus.scrub_en || w_issue) begin
            r_starve <= '0;
         end else if (w_blocked && io_bus.host_req) begin
            r_starve <= r_starve + 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_issue) begin
                  r_state    <= SCRUB_RD;
                  r_mem_addr <= r_scrub_ptr;
                  r_rd1      <= 1'b1;
                  r_own1     <= OWN_SCRUB;
               end else if (w_gnt) begin
                  r_mem_wr   <= io_bus.host_wr;
                  r_mem_addr <= io_bus.host_addr;
                  r_rd1      <= ~io_bus.host_wr;
                  if (io_bus.host_wr) begin
                     r_mem_wdata <= io_bus.host_wdata;
                  end
               end
            end
            SCRUB_RD: r_state <= SCRUB_CHK;
            SCRUB_CHK: begin
               // Corrected data is written straight back to the scrubbed word
               if (w_chk_wb) begin
                  r_state     <= SCRUB_WB;
                  r_mem_wr    <= 1'b1;
                  r_mem_addr  <= r_scrub_ptr;
                  r_mem_wdata <= io_bus.mem_rdata;
               end else begin
                  r_state <= IDLE;
               end
            end
            SCRUB_WB: r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase

         if (w_ptr_adv) begin
            r_scrub_ptr <= r_scrub_ptr + 1'b1;
            r_pass_done <= (r_scrub_ptr == c_PTR_LAST);
         end

         if (io_bus.cnt_clr) begin
            r_irq <= w_uncorr;
         end else if (w_uncorr) begin
            r_irq <= 1'b1;
         end
      end
   end

   err_sat_cnt #(.W(CNT_W)) u_corr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_corr),
      .i_clr (io_bus.cnt_clr),
      .o_cnt (io_bus.corr_cnt)
   );

   err_sat_cnt #(.W(CNT_W)) u_uncorr_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_inc (w_uncorr),
      .i_clr (io_bus.cnt_clr),
      .o_cnt (io_bus.uncorr_cnt)
   );

   assign io_bus.host_gnt        = w_gnt;
   assign io_bus.host_rvalid     = w_host_resp;
   assign io_bus.host_rdata      = w_host_resp ? io_bus.mem_rdata : '0;
   assign io_bus.host_rerr       = w_host_resp & io_bus.mem_err_detected
                                   & ~io_bus.mem_err_corrected;
   assign io_bus.mem_wr          = r_mem_wr;
   assign io_bus.mem_addr        = r_mem_addr;
   assign io_bus.mem_wdata       = r_mem_wdata;
   assign io_bus.err_irq         = r_irq;
   assign io_bus.scrub_pass_done = r_pass_done;

endmodule

`default_nettype wire

// File: tb/tb_crc_mem_scrub_ctrl.sv
//==============================================================================
// Module : tb_crc_mem_scrub_ctrl
// Brief  : Directed bench for the MEM1 scrub controller with a memory model.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_crc_mem_scrub_ctrl;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   logic       inj_en, inj_det, inj_corr;
   logic [7:0] inj_addr;
   logic       mem_init = 1'b0;
   logic [31:0] mem [256];

   crc_mem_scrub_ctrl_if #(.AW(8), .DW(32), .CNT_W(8)) bus ();

   crc_mem_scrub_ctrl #(
      .AW             (8),
      .DW             (32),
      .SCRUB_INTERVAL (4),
      .STARVE_LIMIT   (16),
      .CNT_W          (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: one-cycle read latency with optional error injection
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
         mem_init <= 1'b1;
      end else if (bus.mem_wr) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata         <= mem[bus.mem_addr];
      bus.mem_err_detected  <= inj_en && !bus.mem_wr && (bus.mem_addr == inj_addr) && inj_det;
      bus.mem_err_corrected <= inj_en && !bus.mem_wr && (bus.mem_addr == inj_addr) && inj_corr;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_reset_state(input string pfx);
      chk({pfx, "_gnt"},    bus.host_gnt, 0);
      chk({pfx, "_mwr"},    bus.mem_wr, 0);
      chk({pfx, "_maddr"},  bus.mem_addr, 0);
      chk({pfx, "_mwdata"}, bus.mem_wdata, 0);
      chk({pfx, "_rvalid"}, bus.host_rvalid, 0);
      chk({pfx, "_rdata"},  bus.host_rdata, 0);
      chk({pfx, "_rerr"},   bus.host_rerr, 0);
      chk({pfx, "_corr"},   bus.corr_cnt, 0);
      chk({pfx, "_uncorr"}, bus.uncorr_cnt, 0);
      chk({pfx, "_irq"},    bus.err_irq, 0);
      chk({pfx, "_pass"},   bus.scrub_pass_done, 0);
      chk({pfx, "_ptr"},    dut.r_scrub_ptr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.host_req   = 1'b1;
      bus.host_wr    = 1'b0;
      bus.host_addr  = '0;
      bus.host_wdata = '0;
      bus.scrub_en   = 1'b0;
      bus.cnt_clr    = 1'b0;
      inj_en = 1'b0; inj_det = 1'b0; inj_corr = 1'b0; inj_addr = '0;

      cyc(3); #1;
      chk_reset_state("rst");

      @(negedge clk);
      rst_n = 1'b1;
      bus.host_req = 1'b0;
      cyc(1);

      // Host write then read back of 0x10
      bus.host_req = 1'b1; bus.host_wr = 1'b1;
      bus.host_addr = 8'h10; bus.host_wdata = 32'h1234_5678;
      #1 chk("wr_gnt", bus.host_gnt, 1);
      @(negedge clk);
      chk("wr_mwr", bus.mem_wr, 1);
      chk("wr_maddr", bus.mem_addr, 8'h10);
      chk("wr_mwdata", bus.mem_wdata, 32'h1234_5678);
      bus.host_wr = 1'b0;
      #1 chk("rd_gnt", bus.host_gnt, 1);
      @(negedge clk);
      chk("rd_mwr", bus.mem_wr, 0);
      chk("rd_rvalid_early", bus.host_rvalid, 0);
      bus.host_req = 1'b0;
      @(negedge clk);
      chk("rd_rvalid", bus.host_rvalid, 1);
      chk("rd_rdata", bus.host_rdata, 32'h1234_5678);
      chk("rd_rerr", bus.host_rerr, 0);
      @(negedge clk);
      chk("rd_rvalid_after", bus.host_rvalid, 0);

      // Uncorrectable error on host read of 0x20
      inj_en = 1'b1; inj_addr = 8'h20; inj_det = 1'b1; inj_corr = 1'b0;
      bus.host_req = 1'b1; bus.host_addr = 8'h20;
      @(negedge clk);
      bus.host_req = 1'b0;
      @(negedge clk);
      chk("ue_rvalid", bus.host_rvalid, 1);
      chk("ue_rerr", bus.host_rerr, 1);
      chk("ue_rdata", bus.host_rdata, 32'hA5A5_0020);
      @(negedge clk);
      chk("ue_uncorr", bus.uncorr_cnt, 1);
      chk("ue_irq", bus.err_irq, 1);
      chk("ue_corr", bus.corr_cnt, 0);
      cyc(3);
      chk("ue_irq_sticky", bus.err_irq, 1);

      bus.host_req = 1'b1;
      @(negedge clk);
      bus.host_req = 1'b0;
      @(negedge clk);
      bus.cnt_clr = 1'b1;
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      chk("clr_evt_uncorr", bus.uncorr_cnt, 1);
      chk("clr_evt_irq", bus.err_irq, 1);
      bus.cnt_clr = 1'b1;
      @(negedge clk);
      bus.cnt_clr = 1'b0;
      chk("clr_uncorr", bus.uncorr_cnt, 0);
      chk("clr_irq", bus.err_irq, 0);
      inj_en = 1'b0;

      // Full scrub sweep, correctable error on 0x05 (E = this cycle)
      inj_en = 1'b1; inj_addr = 8'h05; inj_det = 1'b1; inj_corr = 1'b1;
      bus.scrub_en = 1'b1;
      cyc(4);
      chk("scr0_maddr", bus.mem_addr, 8'h00);
      chk("scr0_mwr", bus.mem_wr, 0);
      cyc(5);
      chk("scr0_hold", bus.mem_addr, 8'h00);
      cyc(1);
      chk("scr1_maddr", bus.mem_addr, 8'h01);
      cyc(26);
      chk("wb_mwr", bus.mem_wr, 1);
      chk("wb_maddr", bus.mem_addr, 8'h05);
      chk("wb_mwdata", bus.mem_wdata, 32'hA5A5_0005);
      chk("wb_corr", bus.corr_cnt, 1);
      chk("wb_irq", bus.err_irq, 0);
      cyc(1);
      chk("wb_done_mwr", bus.mem_wr, 0);
      inj_en = 1'b0;
      cyc(1499);
      chk("last_maddr", bus.mem_addr, 8'hFF);
      chk("last_pass", bus.scrub_pass_done, 0);
      chk("last_ptr", dut.r_scrub_ptr, 8'hFF);
      cyc(1);
      chk("wrap_pass", bus.scrub_pass_done, 1);
      chk("wrap_ptr", dut.r_scrub_ptr, 8'h00);
      bus.scrub_en = 1'b0;
      cyc(1);
      chk("wrap_pass_end", bus.scrub_pass_done, 0);

      // Starvation: continuous host reads against an expired interval (F)
      bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 8'h30;
      bus.scrub_en = 1'b1;
      cyc(18); #1;
      chk("stv_gnt_blocked", bus.host_gnt, 1);
      cyc(1); #1;
      chk("stv_force_gnt", bus.host_gnt, 0);
      cyc(1); #1;
      chk("stv_rd_gnt", bus.host_gnt, 0);
      chk("stv_rd_maddr", bus.mem_addr, 8'h00);
      chk("stv_rd_mwr", bus.mem_wr, 0);
      chk("stv_host_resp", bus.host_rvalid, 1);
      cyc(1); #1;
      chk("stv_chk_gnt", bus.host_gnt, 0);
      chk("stv_scrub_resp", bus.host_rvalid, 0);
      cyc(1); #1;
      chk("stv_idle_gnt", bus.host_gnt, 1);
      chk("stv_ptr", dut.r_scrub_ptr, 8'h01);
      bus.host_req = 1'b0;
      bus.scrub_en = 1'b0;
      cyc(3);

      // Reset during SCRUB_CHK with a correctable error pending
      inj_en = 1'b1; inj_addr = 8'h01; inj_det = 1'b1; inj_corr = 1'b1;
      bus.scrub_en = 1'b1;
      cyc(5);
      chk("pre_rst_maddr", bus.mem_addr, 8'h01);
      rst_n = 1'b0;
      bus.host_req = 1'b1;
      #1;
      chk_reset_state("arst");
      cyc(1);
      chk("arst_no_wb", bus.mem_wr, 0);
      rst_n = 1'b1;
      bus.host_req = 1'b0;
      bus.scrub_en = 1'b0;
      inj_en = 1'b0;
      cyc(2);
      chk("post_rst_mwr", bus.mem_wr, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
